fir_mac_sequencer: RTL and testbench

Time-multiplexed FIR control stage for the bistatic radar filter chain. It accepts one signed 32-bit sample at a time and stores it in a circular delay line. It then streams the sample/coefficient pairs for every tap into the external pipelined 32s×8s→32 multiplier and accumulates the returned products. Each sample produces one 32-bit filter output on a valid/ready stream. The block sits both upstream of the multiplier (it drives the operands) and downstream of it (it consumes the products).

---
 rtl/fir_mac_sequencer.sv | 151 +++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// ============================================================================
// Module   : fir_mac_sequencer
// Purpose  : Time-multiplexed FIR tap sequencer driving an external pipelined
//            multiplier and accumulating its products into one output sample.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_mac_sequencer #(
  parameter int NUM_TAPS   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int COEF_WIDTH = 8,
  parameter int AW         = $clog2(NUM_TAPS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  coef_we,
  input  logic [AW-1:0]         coef_addr,
  input  logic [COEF_WIDTH-1:0] coef_wdata,
  output logic                  mul_ce,
  output logic [DATA_WIDTH-1:0] mul_din0,
  output logic [COEF_WIDTH-1:0] mul_din1,
  input  logic [DATA_WIDTH-1:0] mul_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [AW-1:0] c_LAST = AW'(NUM_TAPS - 1);
  localparam logic [AW:0]   c_TAPS = (AW + 1)'(NUM_TAPS);

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_line [NUM_TAPS];
  logic [COEF_WIDTH-1:0] r_coef [NUM_TAPS];
  logic [DATA_WIDTH-1:0] r_acc;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_newest;
  logic [AW-1:0]         r_k;
  logic                  r_issue;
  logic [AW-1:0]         w_rd_idx;
  logic                  w_accept;
  logic                  w_coef_wr;

  assign w_accept  = s_valid && s_ready;
  assign w_coef_wr = coef_we && (r_state == IDLE) && (32'(coef_addr) < 32'(NUM_TAPS));

  // Delay-line read index (newest - k) mod NUM_TAPS, valid for any NUM_TAPS.
  always_comb begin
    w_rd_idx = '0;
    if (r_k <= r_newest) begin
      w_rd_idx = r_newest - r_k;
    end else begin
      w_rd_idx = AW'(({1'b0, r_newest} + c_TAPS) - {1'b0, r_k});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    s_ready  = 1'b0;
    mul_ce   = 1'b0;
    mul_din0 = '0;
    mul_din1 = '0;
    m_valid  = 1'b0;
    m_data   = '0;
    case (r_state)
      IDLE: begin
        s_ready = !reset;
        if (s_valid && !reset) begin
          w_next = MAC;
        end
      end
      MAC: begin
        mul_ce   = 1'b1;
        mul_din0 = r_line[w_rd_idx];
        mul_din1 = r_coef[r_k];
        if (r_k == c_LAST) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        w_next = OUT;
      end
      OUT: begin
        m_valid = 1'b1;
        m_data  = r_acc;
        if (m_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // The issue flag trails the MAC state by one cycle, matching multiplier latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_line[i] <= '0;
        r_coef[i] <= '0;
      end
      r_acc    <= '0;
      r_wr_ptr <= '0;
      r_newest <= '0;
      r_k      <= '0;
      r_issue  <= 1'b0;
    end else begin
      r_issue <= (r_state == MAC);
      if (w_coef_wr) begin
        r_coef[coef_addr] <= coef_wdata;
      end
      if (w_accept) begin
        r_line[r_wr_ptr] <= s_data;
        r_newest         <= r_wr_ptr;
        r_wr_ptr         <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + AW'(1);
        r_acc            <= '0;
        r_k              <= '0;
      end else begin
        if ((r_state == MAC) && (r_k != c_LAST)) begin
          r_k <= r_k + AW'(1);
        end
        if (r_issue) begin
          r_acc <= r_acc + mul_dout;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
// ============================================================================
// Module   : tb_fir_mac_sequencer
// Purpose  : Self-checking bench for fir_mac_sequencer with a multiplier model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_mac_sequencer;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        coef_we;
  logic [1:0]  coef_addr;
  logic [7:0]  coef_wdata;
  logic        mul_ce;
  logic [31:0] mul_din0;
  logic [7:0]  mul_din1;
  logic [31:0] mul_dout = '0;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;

  int tests = 0;
  int fails = 0;

  logic [7:0]  m_h [N];
  logic [31:0] hist [$];

  typedef struct {
    bit          set_h;
    logic [31:0] h;
    logic [31:0] x;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [10];

  fir_mac_sequencer #(.NUM_TAPS(N), .DATA_WIDTH(32), .COEF_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  always #5 clk = ~clk;

  // External multiplier: one register stage, enabled by mul_ce.
  always @(posedge clk) begin
    if (mul_ce) mul_dout <= $signed(mul_din0) * $signed({{24{mul_din1[7]}}, mul_din1});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  function automatic logic [31:0] ref_out();
    logic signed [31:0] acc;
    logic signed [31:0] hk;
    acc = 0;
    foreach (hist[k]) begin
      hk  = {{24{m_h[k][7]}}, m_h[k]};
      acc = acc + $signed(hist[k]) * hk;
    end
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name, output bit ok);
    int n = 0;
    while (!s_ready && n < 100) begin tick(); n++; end
    ok = s_ready;
    if (!ok) timeout(name);
  endtask

  task automatic write_coef(input logic [1:0] a, input logic [7:0] v);
    bit ok;
    wait_ready("coef_wait", ok);
    coef_we = 1'b1; coef_addr = a; coef_wdata = v;
    m_h[a] = v;
    tick();
    coef_we = 1'b0;
  endtask

  // One sample through the filter; optional stall, coefficient poke in MAC or in IDLE.
  task automatic send(input string name, input logic [31:0] x, input int stall,
                      input bit mac_poke, input bit idle_wr,
                      input logic [1:0] a, input logic [7:0] v, output logic [31:0] got);
    bit ok;
    int n;
    logic [31:0] exp;
    got = 'x;
    wait_ready({name, "_rdy"}, ok);
    if (!ok) return;
    s_valid = 1'b1; s_data = x;
    if (idle_wr) begin
      coef_we = 1'b1; coef_addr = a; coef_wdata = v; m_h[a] = v;
    end
    hist.push_front(x);
    if (hist.size() > N) void'(hist.pop_back());
    m_ready = (stall == 0);
    tick();
    s_valid = 1'b0; coef_we = 1'b0;
    if (mac_poke) begin
      tick();
      coef_we = 1'b1; coef_addr = a; coef_wdata = v;
      tick();
      coef_we = 1'b0;
    end
    n = 0;
    while (!m_valid && n < 100) begin tick(); n++; end
    if (!m_valid) begin timeout({name, "_valid"}); m_ready = 1'b1; return; end
    got = m_data;
    exp = ref_out();
    if (stall > 0) begin
      s_valid = 1'b1; s_data = 32'h1234_5678;
      for (int i = 0; i < stall; i++) begin
        tick();
        check({name, "_stall_data"}, m_data, exp);
        check({name, "_stall_ready"}, {31'd0, s_ready}, 32'd0);
      end
      m_ready = 1'b1;
    end
    tick();
    s_valid = 1'b0;
    check({name, "_one_output"}, {31'd0, m_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    bit ok;
    int cnt;
    tbl[0] = '{1'b1, 32'h04030201, 32'd1, 32'd1};
    tbl[1] = '{1'b0, 32'h0, 32'd0, 32'd2};
    tbl[2] = '{1'b0, 32'h0, 32'd0, 32'd3};
    tbl[3] = '{1'b0, 32'h0, 32'd0, 32'd4};
    tbl[4] = '{1'b0, 32'h0, 32'd0, 32'd0};
    tbl[5] = '{1'b1, 32'h01010101, 32'h40000000, 32'h40000000};
    tbl[6] = '{1'b0, 32'h0, 32'h40000000, 32'h80000000};
    tbl[7] = '{1'b0, 32'h0, 32'h40000000, 32'hC0000000};
    tbl[8] = '{1'b0, 32'h0, 32'h40000000, 32'h00000000};
    tbl[9] = '{1'b1, 32'h00000080, 32'h7FFFFFFF, 32'h00000080};
    foreach (m_h[i]) m_h[i] = '0;

    reset = 1'b1; s_valid = 1'b0; s_data = '0; coef_we = 1'b0;
    coef_addr = '0; coef_wdata = '0; m_ready = 1'b1;
    #1;
    check("reset_outputs", {s_ready, m_valid, mul_ce, mul_din0 | m_data, mul_din1},
          32'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    check("reset_sready", {31'd0, s_ready}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].set_h) for (int k = 0; k < N; k++) write_coef(2'(k), tbl[i].h[8*k +: 8]);
      send($sformatf("table%0d", i), tbl[i].x, 0, 1'b0, 1'b0, 2'd0, 8'd0, got);
      check($sformatf("table%0d", i), got, tbl[i].exp);
    end

    // Latency: accept at cycle 0, step cycle by cycle.
    write_coef(2'd1, 8'd3);
    wait_ready("lat_rdy", ok);
    s_valid = 1'b1; s_data = 32'd9;
    hist.push_front(32'd9);
    if (hist.size() > N) void'(hist.pop_back());
    tick();
    s_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("lat_ce_c%0d", c), {31'd0, mul_ce}, {31'd0, c <= 4});
      check($sformatf("lat_valid_c%0d", c), {31'd0, m_valid}, {31'd0, c == 6});
      check($sformatf("lat_ready_c%0d", c), {31'd0, s_ready}, {31'd0, c == 7});
      if (c == 6) check("lat_data", m_data, ref_out());
      if (c < 7) tick();
    end

    send("backpressure", 32'hFFFF_FFF0, 10, 1'b0, 1'b0, 2'd0, 8'd0, got);
    check("backpressure", got, ref_out());

    send("guard_mac", 32'd3, 0, 1'b1, 1'b0, 2'd1, 8'd7, got);
    check("guard_mac", got, ref_out());
    send("guard_idle", 32'd2, 0, 1'b0, 1'b1, 2'd1, 8'd7, got);
    check("guard_idle", got, ref_out());

    // Reset two cycles into MAC must abort the sample and wipe all storage.
    wait_ready("rst_rdy", ok);
    s_valid = 1'b1; s_data = 32'd77;
    tick();
    s_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("rst_mid_outputs", {s_ready, m_valid, mul_ce, mul_din0 | m_data, mul_din1},
          32'd0);
    tick();
    reset = 1'b0;
    hist.delete();
    foreach (m_h[i]) m_h[i] = '0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_valid) cnt++;
      tick();
    end
    check("rst_no_output", cnt, 0);
    write_coef(2'd0, 8'd1);
    send("rst_after", 32'd5, 0, 1'b0, 1'b0, 2'd0, 8'd0, got);
    check("rst_after", got, 32'd5);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) write_coef(2'($urandom_range(0, 3)), 8'($urandom));
      send($sformatf("rand%0d", i), $urandom, $urandom_range(0, 2), 1'b0, 1'b0,
           2'd0, 8'd0, got);
      check($sformatf("rand%0d", i), got, ref_out());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
